// File: rtl/htif_pcr_master_if.sv
// rtl/htif_pcr_master_if.sv - command, response and PCR request/reply signal bundle for htif_pcr_master
interface htif_pcr_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_timeout;

    logic              pcr_req_valid;
    logic              pcr_req_ready;
    logic              pcr_req_rw;
    logic [ADDR_W-1:0] pcr_req_addr;
    logic [DATA_W-1:0] pcr_req_data;

    logic              pcr_rep_valid;
    logic              pcr_rep_ready;
    logic [DATA_W-1:0] pcr_rep_data;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_data, rsp_ready,
               pcr_req_ready, pcr_rep_valid, pcr_rep_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
               pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, pcr_rep_ready
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_data, rsp_ready,
               pcr_req_ready, pcr_rep_valid, pcr_rep_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
               pcr_req_valid, pcr_req_rw, pcr_req_addr, pcr_req_data, pcr_rep_ready
    );
endinterface

// File: rtl/htif_pcr_master.sv
// rtl/htif_pcr_master.sv - single-outstanding HTIF PCR initiator with reply timeout
module htif_pcr_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               rst,
    htif_pcr_master_if.master  bus,
    output logic               busy,
    output logic [7:0]         stray_cnt
);
    localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       timer;
    logic              expired;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_timeout_q;
    logic              timeout_now;

    assign expired = (timer == 16'd0);

    // A handshake in the expiring cycle takes priority over the timeout.
    assign timeout_now = expired &&
                         (((state == REQ)  && !bus.pcr_req_ready) ||
                          ((state == WAIT) && !bus.pcr_rep_valid));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.cmd_valid) state_nxt = REQ;
            REQ: begin
                if (bus.pcr_req_ready)  state_nxt = WAIT;
                else if (expired)       state_nxt = RSP;
            end
            WAIT: if (bus.pcr_rep_valid || expired) state_nxt = RSP;
            RSP:  if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer         <= '0;
            req_rw        <= 1'b0;
            req_addr      <= '0;
            req_data      <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            stray_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        req_rw   <= bus.cmd_rw;
                        req_addr <= bus.cmd_addr;
                        req_data <= bus.cmd_data;
                        timer    <= TIMER_LOAD;
                    end
                end
                REQ, WAIT: begin
                    // Hold at zero so a request accepted on its last cycle still
                    // leaves WAIT with a bounded (one-cycle) reply window.
                    if (!expired) timer <= timer - 16'd1;
                    if ((state == WAIT) && bus.pcr_rep_valid) begin
                        rsp_data_q    <= bus.pcr_rep_data;
                        rsp_timeout_q <= 1'b0;
                    end else if (timeout_now) begin
                        rsp_data_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (bus.pcr_rep_valid && bus.pcr_rep_ready && (state != WAIT) &&
                (stray_cnt != 8'hFF)) begin
                stray_cnt <= stray_cnt + 8'd1;
            end
        end
    end

    assign bus.cmd_ready     = (state == IDLE);
    assign bus.pcr_req_valid = (state == REQ);
    assign bus.pcr_rep_ready = (state == IDLE) || (state == WAIT);
    assign bus.rsp_valid     = (state == RSP);
    assign bus.pcr_req_rw    = req_rw;
    assign bus.pcr_req_addr  = req_addr;
    assign bus.pcr_req_data  = req_data;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign busy              = (state != IDLE);
endmodule

// File: tb/tb_htif_pcr_master.sv
// tb/tb_htif_pcr_master.sv - randomized self-checking bench for htif_pcr_master
module tb_htif_pcr_master;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;
    localparam int T      = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [7:0] stray_cnt;
    int         checks = 0;
    int         errors = 0;
    int         stray_model = 0;

    htif_pcr_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    htif_pcr_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .stray_cnt (stray_cnt)
    );

    always #5 clk = ~clk;

    // One transaction, entered and left on a negedge with the DUT idle.
    // rd: cycles pcr_req_ready stays low; pd: cycles from request accept to reply;
    // sd: cycles rsp_ready stays low once the response is visible.
    task automatic run_txn(input string name, input logic rw, input logic [11:0] addr,
                           input logic [63:0] data, input int rd, input int pd,
                           input int sd, input logic [63:0] rep);
        int          req_end;
        int          rsp_k;
        int          d_rep;
        bit          tmo;
        logic [63:0] exp_data;
        logic        exp_bit;
        if (rd + 1 > T) begin
            req_end = T;
            rsp_k   = T;
            tmo     = 1'b1;
        end else begin
            req_end = rd + 1;
            d_rep   = (T > rd + 2) ? T : rd + 2;
            if (rd + 2 + pd <= d_rep) begin
                rsp_k = rd + 2 + pd;
                tmo   = 1'b0;
            end else begin
                rsp_k = d_rep;
                tmo   = 1'b1;
            end
        end
        exp_data = tmo ? 64'd0 : rep;

        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cmd_ready_at_offer got %b want 1", name, bus.cmd_ready);
        end
        bus.cmd_valid    = 1'b1;
        bus.cmd_rw       = rw;
        bus.cmd_addr     = addr;
        bus.cmd_data     = data;
        bus.pcr_rep_data = rep;
        @(posedge clk);
        for (int k = 0; k <= rsp_k + sd + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_rw    = ~rw;
                bus.cmd_addr  = 12'($urandom());
                bus.cmd_data  = {$urandom(), $urandom()};
            end
            exp_bit = (k < req_end);
            checks++;
            if (bus.pcr_req_valid !== exp_bit) begin
                errors++;
                $display("FAIL %s req_valid k=%0d got %b want %b", name, k, bus.pcr_req_valid, exp_bit);
            end
            if (k < req_end) begin
                checks++;
                if ({bus.pcr_req_rw, bus.pcr_req_addr, bus.pcr_req_data} !== {rw, addr, data}) begin
                    errors++;
                    $display("FAIL %s req_fields k=%0d got %b/%h/%h want %b/%h/%h", name, k,
                             bus.pcr_req_rw, bus.pcr_req_addr, bus.pcr_req_data, rw, addr, data);
                end
            end
            exp_bit = (k >= req_end && k < rsp_k) || (k > rsp_k + sd);
            checks++;
            if (bus.pcr_rep_ready !== exp_bit) begin
                errors++;
                $display("FAIL %s rep_ready k=%0d got %b want %b", name, k, bus.pcr_rep_ready, exp_bit);
            end
            exp_bit = (k >= rsp_k && k <= rsp_k + sd);
            checks++;
            if (bus.rsp_valid !== exp_bit) begin
                errors++;
                $display("FAIL %s rsp_valid k=%0d got %b want %b", name, k, bus.rsp_valid, exp_bit);
            end
            if (exp_bit) begin
                checks++;
                if (bus.rsp_data !== exp_data || bus.rsp_timeout !== tmo) begin
                    errors++;
                    $display("FAIL %s rsp_payload k=%0d got %h/%b want %h/%b", name, k,
                             bus.rsp_data, bus.rsp_timeout, exp_data, tmo);
                end
            end
            exp_bit = (k > rsp_k + sd);
            checks++;
            if (bus.cmd_ready !== exp_bit || busy !== !exp_bit) begin
                errors++;
                $display("FAIL %s cmd_ready_busy k=%0d got %b/%b want %b/%b", name, k,
                         bus.cmd_ready, busy, exp_bit, !exp_bit);
            end
            checks++;
            if (stray_cnt !== 8'(stray_model)) begin
                errors++;
                $display("FAIL %s stray_cnt got %0d want %0d", name, stray_cnt, stray_model);
            end
            bus.pcr_req_ready = (k == rd);
            bus.pcr_rep_valid = !tmo && (k == rd + 1 + pd);
            bus.rsp_ready     = (k >= rsp_k + sd);
        end
        bus.pcr_req_ready = 1'b0;
        bus.pcr_rep_valid = 1'b0;
        bus.rsp_ready     = 1'b0;
    endtask

    task automatic test_reset;
        bus.cmd_valid = 0; bus.cmd_rw = 0; bus.cmd_addr = '0; bus.cmd_data = '0;
        bus.rsp_ready = 0; bus.pcr_req_ready = 0; bus.pcr_rep_valid = 0; bus.pcr_rep_data = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.pcr_rep_ready, bus.pcr_req_valid, bus.rsp_valid, bus.rsp_timeout, busy} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_flags got %b want 110000",
                     {bus.cmd_ready, bus.pcr_rep_ready, bus.pcr_req_valid, bus.rsp_valid, bus.rsp_timeout, busy});
        end
        checks++;
        if ({bus.pcr_req_rw, bus.pcr_req_addr, bus.pcr_req_data, bus.rsp_data, stray_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data got %b/%h/%h/%h/%0d want zeros", bus.pcr_req_rw,
                     bus.pcr_req_addr, bus.pcr_req_data, bus.rsp_data, stray_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_release got %b/%b want 1/0", bus.cmd_ready, busy);
        end
    endtask

    task automatic test_stray(input int n);
        bus.pcr_rep_valid = 1'b1;
        repeat (n) @(negedge clk);
        bus.pcr_rep_valid = 1'b0;
        stray_model = (stray_model + n > 255) ? 255 : stray_model + n;
        @(negedge clk);
        checks++;
        if (stray_cnt !== 8'(stray_model) || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray n=%0d got %0d/%b want %0d/1", n, stray_cnt, bus.cmd_ready, stray_model);
        end
    endtask

    task automatic test_read;
        run_txn("read", 1'b0, 12'h50D, 64'h0, 0, 0, 0, 64'hDEAD_BEEF_0000_0001);
    endtask

    task automatic test_write_backpressure;
        run_txn("write_bp", 1'b1, 12'h51E, 64'h1234, 5, 0, 0, 64'hCAFE_0000_0000_5678);
    endtask

    task automatic test_timeout;
        run_txn("timeout", 1'b0, 12'h123, 64'h0, 0, 100, 0, 64'h1111_2222_3333_4444);
        test_stray(1);
    endtask

    task automatic test_boundary;
        run_txn("edge_wait", 1'b0, 12'h0A5, 64'h0, 1, T - 3, 0, 64'hAAAA_5555_AAAA_5555);
        run_txn("edge_wait0", 1'b1, 12'hFFF, 64'hFFFF, 0, T - 2, 1, 64'h0123_4567_89AB_CDEF);
        run_txn("late_by_one", 1'b0, 12'h001, 64'h0, 0, T - 1, 0, 64'h7777_7777_7777_7777);
        run_txn("req_last_cycle", 1'b1, 12'h3C3, 64'h42, T - 1, 0, 0, 64'h9999_0000_9999_0000);
        run_txn("req_timeout", 1'b1, 12'h2B2, 64'h55, T, 0, 2, 64'h8888_8888_8888_8888);
    endtask

    task automatic test_rsp_backpressure;
        run_txn("rsp_bp", 1'b0, 12'h777, 64'h0, 1, 1, 4, 64'hFEED_FACE_0BAD_F00D);
    endtask

    task automatic test_async_reset;
        bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b1; bus.cmd_addr = 12'h6A6; bus.cmd_data = 64'hABCD;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.pcr_req_ready = 1'b1;
        @(negedge clk);
        bus.pcr_req_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.pcr_rep_ready !== 1'b1 || bus.pcr_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_wait got %b/%b/%b want 1/1/0", busy, bus.pcr_rep_ready, bus.pcr_req_valid);
        end
        #2 rst = 1'b0;
        #1;
        stray_model = 0;
        checks++;
        if ({bus.cmd_ready, bus.pcr_rep_ready, bus.pcr_req_valid, bus.rsp_valid, bus.rsp_timeout, busy} !== 6'b110000 ||
            {bus.pcr_req_rw, bus.pcr_req_addr, bus.pcr_req_data, bus.rsp_data, stray_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset got %b/%h/%h want 110000/0/0",
                     {bus.cmd_ready, bus.pcr_rep_ready, bus.pcr_req_valid, bus.rsp_valid, bus.rsp_timeout, busy},
                     bus.pcr_req_addr, stray_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL aborted_rsp i=%0d got %b/%b want 0/1", i, bus.rsp_valid, bus.cmd_ready);
            end
        end
        run_txn("after_reset", 1'b0, 12'h6A6, 64'h0, 0, 0, 0, 64'h0F0F_0F0F_0F0F_0F0F);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 24; i++) begin
            run_txn("random", 1'($urandom_range(0, 1)), 12'($urandom()), {$urandom(), $urandom()},
                    int'($urandom_range(0, T + 1)), int'($urandom_range(0, T)),
                    int'($urandom_range(0, 3)), {$urandom(), $urandom()});
        end
    endtask

    task automatic test_stray_saturation;
        test_stray(int'($urandom_range(3, 20)));
        test_stray(300);
        test_stray(2);
        run_txn("after_saturation", 1'b1, 12'h0F0, 64'h1, 2, 1, 1, 64'h2222_3333_4444_5555);
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_backpressure();
        test_timeout();
        test_boundary();
        test_rsp_backpressure();
        test_async_reset();
        test_back_to_back();
        test_stray_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/htif_pcr_master.md
# htif_pcr_master

Host-side initiator for the core's HTIF PCR (control-register) port. It drives the `io_host_pcr_req_*` inputs of `Core` and consumes the `io_host_pcr_rep_*` outputs, which the benches currently tie off. A sequencer or test driver issues one read/write command at a time. The block runs the request/reply handshake, bounds the wait with a timeout, and returns the result on a valid/ready response port.

## Interface
Parameters:
- `ADDR_W`, 12, PCR address width; matches `io_host_pcr_req_bits_addr`.
- `DATA_W`, 64, PCR data width; matches req/rep data.
- `TIMEOUT`, 256, cycles allowed from command accept to reply; range 2..65535.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_rw`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  PCR address.
- `cmd_data`  in  DATA_W  write data; ignored for reads.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  DATA_W  reply data; 0 on timeout.
- `rsp_timeout`  out  1  the transaction timed out.
- `pcr_req_valid`  out  1  drives `io_host_pcr_req_valid`.
- `pcr_req_ready`  in  1  from `io_host_pcr_req_ready`.
- `pcr_req_rw`  out  1  drives `io_host_pcr_req_bits_rw`.
- `pcr_req_addr`  out  ADDR_W  drives `io_host_pcr_req_bits_addr`.
- `pcr_req_data`  out  DATA_W  drives `io_host_pcr_req_bits_data`.
- `pcr_rep_valid`  in  1  from `io_host_pcr_rep_valid`.
- `pcr_rep_ready`  out  1  drives `io_host_pcr_rep_ready`.
- `pcr_rep_data`  in  DATA_W  from `io_host_pcr_rep_bits`.
- `busy`  out  1  state is not IDLE.
- `stray_cnt`  out  8  saturating count of replies received while not in WAIT.

## Operation
- FSM with states IDLE, REQ, WAIT, RSP. All outputs are registered or decoded from state, so the block is Moore-only.
- **IDLE:** `cmd_ready`=1 and `pcr_rep_ready`=1 (drains stale replies).
  - On `cmd_valid`: latch rw/addr/data, load `timer`=TIMEOUT-1, go to REQ.
- **REQ:** `pcr_req_valid`=1; rw/addr/data come from the latches and stay stable.
  - On `pcr_req_ready`: go to WAIT.
- **WAIT:** `pcr_rep_ready`=1.
  - On `pcr_rep_valid`: latch `pcr_rep_data` into `rsp_data`, clear `rsp_timeout`, go to RSP.
- **RSP:** `rsp_valid`=1; data and flag stay stable.
  - On `rsp_ready`: go to IDLE.
- **Timer:** 16-bit down-counter, decrements every cycle in REQ and WAIT.
  - If `timer`==0 in REQ or WAIT and the advancing handshake of that state does not occur that cycle: set `rsp_data`=0 and `rsp_timeout`=1, go to RSP.
  - A timeout in REQ withdraws `pcr_req_valid`; this is the only permitted valid drop.
- **Simultaneous events:** a handshake in the same cycle that `timer` hits 0 wins, so no timeout is reported.
- **Stray replies:** a `pcr_rep_valid` while `pcr_rep_ready`=1 in any state other than WAIT increments `stray_cnt`. The count saturates at 255 and never clears except on reset. Such replies do not change the FSM.
- `busy` = (state != IDLE).

## Timing
- **Reset values (async assert, synchronous release):**
  - state = IDLE
  - `cmd_ready`=1, `pcr_rep_ready`=1
  - `pcr_req_valid`=0, `rsp_valid`=0, `rsp_timeout`=0, `busy`=0
  - `pcr_req_rw`/`pcr_req_addr`/`pcr_req_data`=0, `rsp_data`=0
  - `stray_cnt`=0, `timer`=0
- **Reset mid-transaction:** abandon the transaction at once and return to IDLE. No response is produced.
- **Cycle-level latency** (command accepted at edge N, ready/valid partners always asserted):
  - `pcr_req_valid` is high in cycle N+1.
  - WAIT in cycle N+2; the reply is accepted there.
  - `rsp_valid` in cycle N+3.
  - Next `cmd_ready` in cycle N+4.
- **Minimum cost:** 3 cycles from command to response, plus 1 cycle back to IDLE. There is no command pipelining; one transaction is outstanding at a time.
- **Timeout:** with the core silent, `rsp_valid` with `rsp_timeout`=1 rises exactly TIMEOUT+1 cycles after the accept edge.

## Test plan
- **Read:** cmd rw=0, addr=12'h50D; core holds req_ready=1 and returns rep 64'hDEAD_BEEF_0000_0001 one cycle after req. Required: bus shows rw=0, addr=12'h50D; `rsp_data` equals the reply; `rsp_timeout`=0; `rsp_valid` at N+3.
- **Write with backpressure:** cmd rw=1, addr=12'h51E, data=64'h1234; `pcr_req_ready` held low for 5 cycles. Required: `pcr_req_valid` and the fields stay stable throughout; the request is accepted on the 6th cycle; the reply is passed through.
- **Timeout:** TIMEOUT=8; the core never replies. Required: `rsp_valid` rises 9 cycles after accept with `rsp_timeout`=1 and `rsp_data`=0. A late reply after return to IDLE makes `stray_cnt`=1.
- **Boundary:** reply arrives exactly in the cycle `timer`==0. Required: `rsp_timeout`=0 and the data is taken.
- **Response backpressure:** `rsp_ready`=0 for 4 cycles. Required: `rsp_valid`/`rsp_data` stay stable and `cmd_ready`=0 until the handshake.
- **Async reset:** `rst` pulsed low while in WAIT. Required: all outputs take their reset values immediately; `rsp_valid` never asserts for the aborted command; the next command completes normally.
